// File: rtl/sys_bridge_n.sv
// CPU-to-peripheral bridge: slot-decoded, one transaction at a time, device-ack wait states, 2-flop IRQ sync.
// Optional abort of unacknowledged accesses when BRIDGE_TIMEOUT_EN is defined.
module sys_bridge_n #(
  parameter int          NDEV       = 6,
  parameter logic [15:0] BASE       = 16'h7F00,
  parameter int          SLOT_SHIFT = 4,
  parameter int          TIMEOUT    = 15,
  parameter logic [31:0] MISS_DATA  = 32'h80000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    PrReq,
  input  logic [31:0]             PrAddr,
  input  logic [31:0]             PrWD,
  input  logic                    PrWE,
  output logic [31:0]             PrRD,
  output logic                    PrReady,
  output logic                    PrErr,
  output logic [NDEV-1:0]         HWInt,
  output logic [NDEV-1:0]         DEVStb,
  output logic [NDEV-1:0]         DEVWE,
  output logic [SLOT_SHIFT-3:0]   DEVAddr,
  output logic [31:0]             DEVWD,
  input  logic [NDEV*32-1:0]      DEVRD,
  input  logic [NDEV-1:0]         DEVAck,
  input  logic [NDEV-1:0]         DEVInt
);

  localparam int IDXW = (NDEV > 1) ? $clog2(NDEV) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    we_q, we_d;
  logic [SLOT_SHIFT-3:0]   devaddr_q, devaddr_d;
  logic [31:0]             devwd_q, devwd_d;
  logic [31:0]             prrd_q, prrd_d;
  logic                    prerr_q, prerr_d;
  logic [NDEV-1:0]         sync1_q, sync1_d;
  logic [NDEV-1:0]         sync2_q, sync2_d;

  logic [15:0]             off;
  logic [15:0]             idx_full;
  logic                    hit;
  logic                    sel_ack;
  logic [31:0]             sel_rd;
  logic                    unused_ok;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0]           cnt_q, cnt_d;
`endif

  // Word-aligned slot decode on the low half-word only.
  assign off       = PrAddr[15:0] - BASE;
  assign idx_full  = off >> SLOT_SHIFT;
  assign hit       = (PrAddr[15:0] >= BASE) && (idx_full < 16'(NDEV));
  assign sel_ack   = DEVAck[int'(idx_q)];
  assign sel_rd    = DEVRD[int'(idx_q)*32 +: 32];
  assign unused_ok = ^{PrAddr[31:16], PrAddr[1:0], off[1:0]};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    we_d      = we_q;
    devaddr_d = devaddr_q;
    devwd_d   = devwd_q;
    prrd_d    = prrd_q;
    prerr_d   = prerr_q;
    sync1_d   = DEVInt;
    sync2_d   = sync1_q;
`ifdef BRIDGE_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (PrReq) begin
          if (hit) begin
            idx_d     = idx_full[IDXW-1:0];
            we_d      = PrWE;
            devaddr_d = off[SLOT_SHIFT-1:2];
            devwd_d   = PrWD;
            state_d   = ACCESS;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end else begin
            prrd_d  = MISS_DATA;
            prerr_d = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        // An ack in the expiry cycle still completes normally.
        if (sel_ack) begin
          prrd_d  = sel_rd;
          prerr_d = 1'b0;
          state_d = RESP;
        end
`ifdef BRIDGE_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prrd_d  = MISS_DATA;
          prerr_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      we_q      <= 1'b0;
      devaddr_q <= '0;
      devwd_q   <= '0;
      prrd_q    <= '0;
      prerr_q   <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      devaddr_q <= devaddr_d;
      devwd_q   <= devwd_d;
      prrd_q    <= prrd_d;
      prerr_q   <= prerr_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign DEVStb  = (state_q == ACCESS) ? (NDEV'(1) << idx_q) : '0;
  assign DEVWE   = DEVStb & {NDEV{we_q}};
  assign DEVAddr = devaddr_q;
  assign DEVWD   = devwd_q;
  assign PrRD    = prrd_q;
  assign PrErr   = prerr_q;
  assign PrReady = (state_q == RESP);
  assign HWInt   = sync2_q;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed bench for sys_bridge_n: scoreboarded CPU transactions against simple ack-delay device models.
module tb_sys_bridge_n;
  localparam int NDEV = 6;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 PrReq;
  logic [31:0]          PrAddr;
  logic [31:0]          PrWD;
  logic                 PrWE;
  logic [31:0]          PrRD;
  logic                 PrReady;
  logic                 PrErr;
  logic [NDEV-1:0]      HWInt;
  logic [NDEV-1:0]      DEVStb;
  logic [NDEV-1:0]      DEVWE;
  logic [1:0]           DEVAddr;
  logic [31:0]          DEVWD;
  logic [NDEV*32-1:0]   DEVRD;
  logic [NDEV-1:0]      DEVAck;
  logic [NDEV-1:0]      DEVInt;

  int              ack_wait  = 0;
  logic [NDEV-1:0] ack_noise = '0;
  int              stb_cnt   = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  sys_bridge_n dut (
    .clk(clk), .reset(reset), .PrReq(PrReq), .PrAddr(PrAddr), .PrWD(PrWD), .PrWE(PrWE),
    .PrRD(PrRD), .PrReady(PrReady), .PrErr(PrErr), .HWInt(HWInt), .DEVStb(DEVStb),
    .DEVWE(DEVWE), .DEVAddr(DEVAddr), .DEVWD(DEVWD), .DEVRD(DEVRD), .DEVAck(DEVAck),
    .DEVInt(DEVInt)
  );

  always #5 clk = ~clk;

  // Selected device acks once its strobe has been held ack_wait cycles.
  always @(posedge clk) stb_cnt <= (DEVStb == '0) ? 0 : stb_cnt + 1;
  assign DEVAck = (DEVStb & {NDEV{stb_cnt >= ack_wait}}) | ack_noise;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic we, input logic [31:0] erd, input logic eerr, input int elat,
                        input logic [NDEV-1:0] estb, input logic [1:0] eaddr, input int ecyc);
    exp_t e;
    exp_t got;
    int   lat = 0;
    int   stbc = 0;
    int   stb_bad = 0;
    int   wec = 0;
    bit   done = 0;
    @(negedge clk);
    e.rd = erd;
    e.err = eerr;
    sb.push_back(e);
    PrAddr = addr; PrWD = wd; PrWE = we; PrReq = 1'b1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (DEVStb != '0) begin
        stbc++;
        if (DEVStb !== estb) stb_bad++;
        if (DEVWE === (we ? estb : '0)) wec++;
        if (stbc == 1) begin
          check({tag, "_addr"}, 64'(DEVAddr), 64'(eaddr));
          check({tag, "_wd"}, 64'(DEVWD), 64'(wd));
        end
      end
      if (PrReady) done = 1;
    end
    PrReq = 1'b0;
    check({tag, "_ready"}, 64'(done), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_stbcyc"}, 64'(stbc), 64'(ecyc));
    check({tag, "_stbbad"}, 64'(stb_bad), 64'd0);
    check({tag, "_wecyc"}, 64'(wec), 64'(ecyc));
    if (done) begin
      got = sb.pop_front();
      check({tag, "_rd"}, 64'(PrRD), 64'(got.rd));
      check({tag, "_err"}, 64'(PrErr), 64'(got.err));
    end
  endtask

  initial begin
    int rdy_seen;
    logic [NDEV-1:0] exp_int;
    for (int i = 0; i < NDEV; i++) DEVRD[i*32 +: 32] = 32'hCAFE0000 | 32'(i);
    reset = 1'b1; PrReq = 1'b0; PrAddr = '0; PrWD = '0; PrWE = 1'b0; DEVInt = '0;
    repeat (3) @(negedge clk);
    check("rst_prrd", 64'(PrRD), 64'd0);
    check("rst_ready", 64'(PrReady), 64'd0);
    check("rst_err", 64'(PrErr), 64'd0);
    check("rst_stb", 64'(DEVStb), 64'd0);
    check("rst_we", 64'(DEVWE), 64'd0);
    check("rst_addr", 64'(DEVAddr), 64'd0);
    check("rst_wd", 64'(DEVWD), 64'd0);
    check("rst_hwint", 64'(HWInt), 64'd0);
    reset = 1'b0;

    do_req("rd0w", 32'h00007F24, 32'h0, 1'b0, 32'hCAFE0002, 1'b0, 2, 6'b000100, 2'd1, 1);
    repeat (3) @(negedge clk);
    check("hold_rd", 64'(PrRD), 64'hCAFE0002);
    check("hold_ready", 64'(PrReady), 64'd0);

    // Device 1 waits while unselected device 0 asserts a stray ack.
    ack_wait = 2; ack_noise = 6'b000001;
    do_req("wr3w", 32'h00007F10, 32'h12345678, 1'b1, 32'hCAFE0001, 1'b0, 4, 6'b000010, 2'd0, 3);
    ack_wait = 0; ack_noise = '0;

    do_req("miss_hi", 32'h00007F60, 32'h0, 1'b0, 32'h80000000, 1'b1, 1, '0, 2'd0, 0);
    do_req("miss_lo", 32'h00007EFC, 32'h0, 1'b1, 32'h80000000, 1'b1, 1, '0, 2'd0, 0);
    do_req("wr_hi", 32'h12347F5C, 32'hA5A5F00D, 1'b1, 32'hCAFE0005, 1'b0, 2, 6'b100000, 2'd3, 1);
    do_req("rd_d3", 32'hFFFF7F38, 32'h0, 1'b0, 32'hCAFE0003, 1'b0, 2, 6'b001000, 2'd2, 1);

`ifdef BRIDGE_TIMEOUT_EN
    ack_wait = 1000;
    do_req("tmo", 32'h00007F00, 32'h0, 1'b0, 32'h80000000, 1'b1, 16, 6'b000001, 2'd0, 15);
    ack_wait = 14;
    do_req("tmo_ack", 32'h00007F00, 32'h0, 1'b0, 32'hCAFE0000, 1'b0, 16, 6'b000001, 2'd0, 15);
    ack_wait = 0;
`endif

    // Reset in the second strobe cycle of a read that never acks.
    ack_wait = 1000;
    @(negedge clk);
    PrAddr = 32'h00007F00; PrWE = 1'b0; PrReq = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_stb_pre", 64'(DEVStb), 64'b000001);
    reset = 1'b1;
    #1;
    check("mid_stb_rst", 64'(DEVStb), 64'd0);
    check("mid_we_rst", 64'(DEVWE), 64'd0);
    PrReq = 1'b0;
    rdy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (PrReady) rdy_seen++;
    end
    check("mid_noready", 64'(rdy_seen), 64'd0);
    reset = 1'b0; ack_wait = 0;
    do_req("post_rst", 32'h00007F04, 32'h0, 1'b0, 32'hCAFE0000, 1'b0, 2, 6'b000001, 2'd1, 1);

    // Five-cycle pulse on DEVInt[4]; HWInt should follow two cycles later.
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      DEVInt = (j < 5) ? 6'b010000 : 6'b000000;
      @(negedge clk);
      exp_int = (j + 1 >= 2 && j + 1 <= 6) ? 6'b010000 : 6'b000000;
      check($sformatf("irq_%0d", j + 1), 64'(HWInt), 64'(exp_int));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
